// File: rtl/rr_arb8_sel.sv
// rr_arb8_sel: 8-channel round-robin arbiter feeding a 3-to-8 decoder.
// Holds each grant until done, requester drop or the hold limit, then
// forces a one-cycle idle gap before the next owner is selected.
module rr_arb8_sel #(
   parameter int unsigned HOLD_W   = 4,
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic       gnt_valid,
   output logic [2:0] gnt_sel,
   output logic       timeout
);

   localparam int unsigned N     = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SEL_W-1:0]    ptr_q;
   logic [SEL_W-1:0]    ptr_d;
   logic [HOLD_W-1:0]   hold_q;
   logic [HOLD_W-1:0]   hold_d;
   logic                valid_d;
   logic [SEL_W-1:0]    sel_d;
   logic                timeout_d;

   logic                win_found;
   logic [SEL_W-1:0]    win_idx;
   logic [SEL_W-1:0]    cand;
   logic                limit_hit;
   logic                req_drop;
   logic                release_now;

   // Rotating priority search: ptr+1 is highest, ptr itself is lowest.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int i = N; i >= 1; i--) begin
         cand = ptr_q + SEL_W'(i);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Release conditions for the current grant; limit disabled when HOLD_MAX is 0.
   always_comb begin
      limit_hit   = (HOLD_MAX != 0) && (hold_q == HOLD_W'(HOLD_MAX));
      req_drop    = ~req[gnt_sel];
      release_now = done | req_drop | limit_hit;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      valid_d   = gnt_valid;
      sel_d     = gnt_sel;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (en && win_found) begin
               sel_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = HOLD_W'(1);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d   = IDLE;
               valid_d   = 1'b0;
               ptr_d     = gnt_sel;
               timeout_d = limit_hit & ~done & ~req_drop;
            end else if (hold_q != {HOLD_W{1'b1}}) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= SEL_W'(N - 1);
         hold_q    <= '0;
         gnt_valid <= 1'b0;
         gnt_sel   <= '0;
         timeout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_valid <= valid_d;
         gnt_sel   <= sel_d;
         timeout   <= timeout_d;
      end
   end

endmodule

// File: tb/tb_rr_arb8_sel.sv
// Directed self-checking bench for rr_arb8_sel.
module tb_rr_arb8_sel;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic       gnt_valid;
   logic [2:0] gnt_sel;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arb8_sel #(.HOLD_W(4), .HOLD_MAX(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt_valid (gnt_valid),
      .gnt_sel   (gnt_sel),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   // Advance one clock; outputs settle and new inputs are applied 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release any grant and park in IDLE with no requests.
   task automatic go_idle();
      req  = 8'h00;
      done = 1'b1;
      tick();
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL go_idle: gnt_valid=%b required 0", gnt_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
      tick(); tick();
      n_checks++;
      if ({gnt_valid, gnt_sel, timeout} !== 5'b0_000_0) begin
         n_fail++;
         $display("FAIL reset: v/sel/to=%b/%0d/%b required 0/0/0", gnt_valid, gnt_sel, timeout);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      req = 8'hFF; en = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         exp = 3'(i % 8);
         n_checks++;
         if ({gnt_valid, gnt_sel} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: v/sel=%b/%0d required 1/%0d", i, gnt_valid, gnt_sel, exp);
         end
         done = 1'b1;
         tick();
         n_checks++;
         if ({gnt_valid, gnt_sel, timeout} !== {1'b0, exp, 1'b0}) begin
            n_fail++;
            $display("FAIL rr_gap[%0d]: v/sel/to=%b/%0d/%b required 0/%0d/0", i, gnt_valid, gnt_sel, timeout, exp);
         end
         done = 1'b0;
         tick();
      end
      go_idle();
   endtask

   task automatic test_pointer();
      req = 8'b0000_0100;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd2}) begin
         n_fail++;
         $display("FAIL ptr_setup: v/sel=%b/%0d required 1/2", gnt_valid, gnt_sel);
      end
      go_idle();
      req = 8'b0000_0101;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL ptr_after2: v/sel=%b/%0d required 1/0", gnt_valid, gnt_sel);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd2}) begin
         n_fail++;
         $display("FAIL ptr_after0: v/sel=%b/%0d required 1/2", gnt_valid, gnt_sel);
      end
      go_idle();
   endtask

   task automatic test_hold_limit();
      int high = 0;
      req = 8'b0010_0000;
      tick();
      for (int i = 0; i < 15; i++) begin
         if (gnt_valid === 1'b1 && gnt_sel === 3'd5 && timeout === 1'b0) high++;
         tick();
      end
      n_checks++;
      if (high != 15) begin
         n_fail++;
         $display("FAIL hold_high_cycles: %0d required 15", high);
      end
      n_checks++;
      if ({gnt_valid, timeout} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_timeout_gap: v/to=%b/%b required 0/1", gnt_valid, timeout);
      end
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel, timeout} !== {1'b1, 3'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_regrant: v/sel/to=%b/%0d/%b required 1/5/0", gnt_valid, gnt_sel, timeout);
      end
      go_idle();
   endtask

   task automatic test_release_causes();
      req = 8'b0000_1000;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd3}) begin
         n_fail++;
         $display("FAIL drop_grant: v/sel=%b/%0d required 1/3", gnt_valid, gnt_sel);
      end
      tick(); tick();
      req = 8'h00;
      tick();
      n_checks++;
      if ({gnt_valid, timeout} !== 2'b00) begin
         n_fail++;
         $display("FAIL drop_release: v/to=%b/%b required 0/0", gnt_valid, timeout);
      end
      req = 8'b0000_1000;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd3}) begin
         n_fail++;
         $display("FAIL limit_done_grant: v/sel=%b/%0d required 1/3", gnt_valid, gnt_sel);
      end
      for (int i = 0; i < 14; i++) tick();
      n_checks++;
      if (gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL limit_done_pre: gnt_valid=%b required 1", gnt_valid);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if ({gnt_valid, timeout} !== 2'b00) begin
         n_fail++;
         $display("FAIL limit_done_release: v/to=%b/%b required 0/0", gnt_valid, timeout);
      end
      go_idle();
   endtask

   task automatic test_enable();
      req = 8'b0100_0000; en = 1'b1;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd6}) begin
         n_fail++;
         $display("FAIL en_grant: v/sel=%b/%0d required 1/6", gnt_valid, gnt_sel);
      end
      en = 1'b0; req = 8'hFF;
      tick(); tick(); tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd6}) begin
         n_fail++;
         $display("FAIL en_persist: v/sel=%b/%0d required 1/6", gnt_valid, gnt_sel);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL en_blocked: gnt_valid=%b required 0", gnt_valid);
      end
      en = 1'b1;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd7}) begin
         n_fail++;
         $display("FAIL en_resume: v/sel=%b/%0d required 1/7", gnt_valid, gnt_sel);
      end
      go_idle();
   endtask

   task automatic test_reset_mid_grant();
      req = 8'b0001_0000;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd4}) begin
         n_fail++;
         $display("FAIL rst_mid_grant: v/sel=%b/%0d required 1/4", gnt_valid, gnt_sel);
      end
      tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel, timeout} !== 5'b0_000_0) begin
         n_fail++;
         $display("FAIL rst_mid_clear: v/sel/to=%b/%0d/%b required 0/0/0", gnt_valid, gnt_sel, timeout);
      end
      rst_n = 1'b1; req = 8'hFF;
      tick();
      n_checks++;
      if ({gnt_valid, gnt_sel} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL rst_first_grant: v/sel=%b/%0d required 1/0", gnt_valid, gnt_sel);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_pointer();
      test_hold_limit();
      test_release_causes();
      test_enable();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
